// File: rtl/rs_ooo_pkg.sv
// Shared types for the out-of-order reservation station: physical-register tags,
// issue packets and the per-entry storage record.
package rs_ooo_pkg;

  localparam int unsigned PREG_W = 6;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] phys_reg;
    logic              ready;
  } TAG;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  opcode;
    TAG          t;
    TAG          t1;
    TAG          t2;
  } ID_IS_PACKET;

  typedef struct packed {
    logic        busy;
    logic        issued;
    ID_IS_PACKET pkt;
  } RS_OOO_ENTRY;

  // An absent source operand never blocks issue.
  function automatic logic operands_ready(input ID_IS_PACKET p);
    return (!p.t1.valid || p.t1.ready) && (!p.t2.valid || p.t2.ready);
  endfunction

endpackage

// File: rtl/rs_ooo_if.sv
// Dispatch / wakeup / issue / remove bundle between the pipeline and the reservation station.
interface rs_ooo_if import rs_ooo_pkg::*; #(
  parameter int unsigned RS_SZ   = 8,
  parameter int unsigned NUM_CDB = 2
) ();
  localparam int unsigned IDX_W = $clog2(RS_SZ);
  localparam int unsigned CNT_W = $clog2(RS_SZ + 1);

  TAG [NUM_CDB-1:0] cdb;
  ID_IS_PACKET      dispatch_packet;
  logic             dispatch_en;
  logic [IDX_W-1:0] dispatch_idx;
  logic             full;
  logic [CNT_W-1:0] free_count;
  ID_IS_PACKET      issue_packet;
  logic [IDX_W-1:0] issue_idx;
  logic             issue_valid;
  logic             issue_ready;
  logic [IDX_W-1:0] remove_idx;
  logic             remove_en;
  logic             flush;

  modport master (
    output cdb, dispatch_packet, dispatch_en, issue_ready, remove_idx, remove_en, flush,
    input  dispatch_idx, full, free_count, issue_packet, issue_idx, issue_valid
  );

  modport slave (
    input  cdb, dispatch_packet, dispatch_en, issue_ready, remove_idx, remove_en, flush,
    output dispatch_idx, full, free_count, issue_packet, issue_idx, issue_valid
  );

endinterface

// File: rtl/rs_ooo_age_select.sv
// Age matrix with oldest-ready picker; age[i][j]=1 means entry i is older than entry j.
module rs_age_select #(
  parameter int unsigned RS_SZ = 8,
  parameter int unsigned IDX_W = $clog2(RS_SZ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [RS_SZ-1:0] ready,
  input  logic [RS_SZ-1:0] alloc,
  input  logic [RS_SZ-1:0] free,
  output logic [RS_SZ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [RS_SZ-1:0] age [RS_SZ];
  logic [RS_SZ-1:0] blocked;

  // A new entry gets an all-zero row and a set column, making it younger than everyone;
  // stale bits against idle entries are rewritten when those entries are allocated.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int unsigned i = 0; i < RS_SZ; i++) age[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_SZ; i++) begin
        for (int unsigned j = 0; j < RS_SZ; j++) begin
          if (alloc[i])                age[i][j] <= 1'b0;
          else if (alloc[j])           age[i][j] <= 1'b1;
          else if (free[i] || free[j]) age[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    blocked   = '0;
    grant     = '0;
    grant_idx = '0;
    for (int unsigned i = 0; i < RS_SZ; i++) begin
      for (int unsigned j = 0; j < RS_SZ; j++) begin
        if (ready[j] && age[j][i]) blocked[i] = 1'b1;
      end
      grant[i] = ready[i] && !blocked[i];
      if (grant[i]) grant_idx = IDX_W'(i);
    end
    grant_valid = |ready;
  end

endmodule

// File: rtl/rs_ooo.sv
// R10K-style reservation station: associative entries, CDB tag wakeup with same-cycle
// dispatch capture, oldest-ready issue over valid/ready, per-index removal and flush.
module rs_ooo import rs_ooo_pkg::*; #(
  parameter int unsigned RS_SZ   = 8,
  parameter int unsigned NUM_CDB = 2
) (
  input logic     clock,
  input logic     reset,
  rs_ooo_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(RS_SZ);
  localparam int unsigned CNT_W = $clog2(RS_SZ + 1);

  RS_OOO_ENTRY      entries     [RS_SZ];
  RS_OOO_ENTRY      entries_nxt [RS_SZ];
  logic [RS_SZ-1:0] busy;
  logic [RS_SZ-1:0] rdy;
  logic [RS_SZ-1:0] alloc;
  logic [RS_SZ-1:0] free;
  logic [RS_SZ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic [IDX_W-1:0] free_idx;
  logic [CNT_W-1:0] free_cnt;
  logic             dispatch_fire;
  logic             issue_fire;

  function automatic logic cdb_hit(input TAG t, input TAG [NUM_CDB-1:0] c);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (t.valid && c[k].valid && (t.phys_reg == c[k].phys_reg)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    free_idx = '0;
    free_cnt = '0;
    for (int unsigned i = 0; i < RS_SZ; i++) begin
      busy[i] = entries[i].busy;
      rdy[i]  = entries[i].busy && !entries[i].issued && operands_ready(entries[i].pkt);
      if (!entries[i].busy) free_cnt = free_cnt + CNT_W'(1);
    end
    for (int unsigned i = RS_SZ; i > 0; i--) begin
      if (!busy[i-1]) free_idx = IDX_W'(i - 1);
    end
  end

  assign dispatch_fire = bus.dispatch_en && !(&busy) && !bus.flush;
  assign issue_fire    = grant_valid && bus.issue_ready;

  always_comb begin
    for (int unsigned i = 0; i < RS_SZ; i++) begin
      alloc[i] = dispatch_fire && (free_idx == IDX_W'(i));
      free[i]  = bus.remove_en && (bus.remove_idx == IDX_W'(i)) && busy[i];
    end
  end

  // Remove is applied after issue so a same-index accept+remove frees the entry;
  // alloc only targets idle entries, so it never collides with remove.
  always_comb begin
    for (int unsigned i = 0; i < RS_SZ; i++) begin
      entries_nxt[i] = entries[i];
      if (entries[i].busy) begin
        if (cdb_hit(entries[i].pkt.t1, bus.cdb)) entries_nxt[i].pkt.t1.ready = 1'b1;
        if (cdb_hit(entries[i].pkt.t2, bus.cdb)) entries_nxt[i].pkt.t2.ready = 1'b1;
      end
      if (issue_fire && grant[i]) entries_nxt[i].issued = 1'b1;
      if (free[i]) begin
        entries_nxt[i].busy   = 1'b0;
        entries_nxt[i].issued = 1'b0;
      end
      if (alloc[i]) begin
        entries_nxt[i].busy        = 1'b1;
        entries_nxt[i].issued      = 1'b0;
        entries_nxt[i].pkt         = bus.dispatch_packet;
        entries_nxt[i].pkt.t1.ready = bus.dispatch_packet.t1.ready
                                      | cdb_hit(bus.dispatch_packet.t1, bus.cdb);
        entries_nxt[i].pkt.t2.ready = bus.dispatch_packet.t2.ready
                                      | cdb_hit(bus.dispatch_packet.t2, bus.cdb);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      for (int unsigned i = 0; i < RS_SZ; i++) entries[i] <= '0;
    end else begin
      entries <= entries_nxt;
    end
  end

  rs_age_select #(
    .RS_SZ (RS_SZ),
    .IDX_W (IDX_W)
  ) u_age (
    .clock       (clock),
    .reset       (reset),
    .flush       (bus.flush),
    .ready       (rdy),
    .alloc       (alloc),
    .free        (free),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign bus.dispatch_idx = free_idx;
  assign bus.full         = &busy;
  assign bus.free_count   = free_cnt;
  assign bus.issue_valid  = grant_valid;
  assign bus.issue_idx    = grant_idx;
  assign bus.issue_packet = entries[grant_idx].pkt;

endmodule

// File: tb/tb_rs_ooo.sv
// Directed vector bench for rs_ooo: one vector per clock, outputs checked 1ns after the edge.
module tb_rs_ooo;
  import rs_ooo_pkg::*;

  typedef struct {
    logic de; int pc; logic t1v; int t1r; logic t2v; int t2r;
    logic c0v; int c0; logic c1v; int c1;
    logic ir; logic re; int ridx; logic fl;
    logic e_full; int e_fc; logic e_iv; int e_iidx; int e_pc; int e_didx;
  } vec_t;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  rs_ooo_if #(.RS_SZ(8), .NUM_CDB(2)) bus ();

  rs_ooo #(.RS_SZ(8), .NUM_CDB(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic vec_t mk(logic de, int pc, logic t1v, int t1r, logic t2v, int t2r,
                              logic c0v, int c0, logic c1v, int c1, logic ir, logic re,
                              int ridx, logic fl, logic ef, int efc, logic eiv, int eii,
                              int epc, int edi);
    vec_t v;
    v.de = de; v.pc = pc; v.t1v = t1v; v.t1r = t1r; v.t2v = t2v; v.t2r = t2r;
    v.c0v = c0v; v.c0 = c0; v.c1v = c1v; v.c1 = c1;
    v.ir = ir; v.re = re; v.ridx = ridx; v.fl = fl;
    v.e_full = ef; v.e_fc = efc; v.e_iv = eiv; v.e_iidx = eii; v.e_pc = epc; v.e_didx = edi;
    return v;
  endfunction

  function automatic ID_IS_PACKET mk_pkt(int pc, logic t1v, int t1r, logic t2v, int t2r);
    ID_IS_PACKET p;
    p = '0;
    p.pc          = 16'(pc);
    p.opcode      = 8'h11;
    p.t.valid     = 1'b1;
    p.t.phys_reg  = PREG_W'(pc + 32);
    p.t1.valid    = t1v;
    p.t1.phys_reg = PREG_W'(t1r);
    p.t2.valid    = t2v;
    p.t2.phys_reg = PREG_W'(t2r);
    return p;
  endfunction

  function automatic TAG mk_tag(logic v, int r);
    TAG t;
    t.valid    = v;
    t.phys_reg = PREG_W'(r);
    t.ready    = 1'b0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.dispatch_en     = 1'b0;
    bus.dispatch_packet = '0;
    bus.cdb[0]          = mk_tag(1'b0, 0);
    bus.cdb[1]          = mk_tag(1'b0, 0);
    bus.issue_ready     = 1'b0;
    bus.remove_en       = 1'b0;
    bus.remove_idx      = '0;
    bus.flush           = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int n);
    @(negedge clock);
    bus.dispatch_en     = v.de;
    bus.dispatch_packet = mk_pkt(v.pc, v.t1v, v.t1r, v.t2v, v.t2r);
    bus.cdb[0]          = mk_tag(v.c0v, v.c0);
    bus.cdb[1]          = mk_tag(v.c1v, v.c1);
    bus.issue_ready     = v.ir;
    bus.remove_en       = v.re;
    bus.remove_idx      = 3'(v.ridx);
    bus.flush           = v.fl;
    @(posedge clock);
    #1;
    chk($sformatf("v%0d.full", n), 32'(bus.full), 32'(v.e_full));
    chk($sformatf("v%0d.free_count", n), 32'(bus.free_count), v.e_fc);
    chk($sformatf("v%0d.issue_valid", n), 32'(bus.issue_valid), 32'(v.e_iv));
    if (v.e_iidx >= 0) begin
      chk($sformatf("v%0d.issue_idx", n), 32'(bus.issue_idx), v.e_iidx);
      chk($sformatf("v%0d.issue_pc", n), 32'(bus.issue_packet.pc), v.e_pc);
    end
    if (v.e_didx >= 0) chk($sformatf("v%0d.dispatch_idx", n), 32'(bus.dispatch_idx), v.e_didx);
  endtask

  initial begin
    int waited;
    // Fill all eight, overflow, issue, remove, re-dispatch, accept+remove same index, flush.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, i+1, 0,0,0,0, 0,0,0,0, 0,0,0,0, (i == 7), 7-i, 1, 0, 1, (i < 7) ? i+1 : -1));
    vecs.push_back(mk(1, 9,  0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,1,0,1,-1));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 1,0,0,0, 1,0,1,1,2,-1));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 0,1,0,0, 0,1,1,1,2,0));
    vecs.push_back(mk(1, 10, 0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,1,1,2,-1));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 1,1,1,0, 0,1,1,2,3,1));
    vecs.push_back(mk(1, 11, 0,0,0,0, 0,0,0,0, 0,1,2,1, 0,8,0,-1,0,0));
    // A waits on PR5, B ready and issues first, PR5 broadcast wakes A.
    vecs.push_back(mk(1, 20, 1,5,0,0, 0,0,0,0, 0,0,0,0, 0,7,0,-1,0,1));
    vecs.push_back(mk(1, 21, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,6,1,1,21,2));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 1,0,0,0, 0,6,0,-1,0,2));
    vecs.push_back(mk(0, 0,  0,0,0,0, 1,5,0,0, 0,0,0,0, 0,6,1,0,20,2));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 1,0,0,0, 0,6,0,-1,0,2));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 0,1,0,0, 0,7,0,-1,0,0));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 0,1,1,0, 0,8,0,-1,0,0));
    // Same-cycle capture of PR9, non-matching CDB, t2 wakeup from cdb[1].
    vecs.push_back(mk(1, 30, 1,9,0,0,  0,0,1,9,   0,0,0,0, 0,7,1,0,30,1));
    vecs.push_back(mk(1, 31, 0,0,1,12, 1,13,0,0,  0,0,0,0, 0,6,1,0,30,2));
    vecs.push_back(mk(0, 0,  0,0,0,0,  0,0,1,12,  1,0,0,0, 0,6,1,1,31,2));
    // issue_ready held low for three cycles, then accepted and removed.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,6,1,1,31,2));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 1,0,0,0, 0,6,0,-1,0,2));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 0,1,1,0, 0,7,0,-1,0,1));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 0,1,0,0, 0,8,0,-1,0,0));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 0,1,5,0, 0,8,0,-1,0,0));
    // Five entries then flush alongside dispatch and remove.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 40+i, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,7-i,1,0,40,i+1));
    vecs.push_back(mk(1, 45, 0,0,0,0, 0,0,0,0, 0,1,2,1, 0,8,0,-1,0,0));
    // Entries 0..3 busy, remove 2 while dispatching: lands in 4, then 2 is next and youngest.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 50+i, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,7-i,1,0,50,i+1));
    vecs.push_back(mk(1, 54, 0,0,0,0, 0,0,0,0, 0,1,2,0, 0,4,1,0,50,2));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 1,0,0,0, 0,4,1,1,51,2));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 1,0,0,0, 0,4,1,3,53,2));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 1,0,0,0, 0,4,1,4,54,2));
    vecs.push_back(mk(0, 0,  0,0,0,0, 0,0,0,0, 1,0,0,0, 0,4,0,-1,0,2));
    vecs.push_back(mk(1, 55, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,3,1,2,55,5));

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("reset.full", 32'(bus.full), 0);
    chk("reset.free_count", 32'(bus.free_count), 8);
    chk("reset.issue_valid", 32'(bus.issue_valid), 0);
    chk("reset.dispatch_idx", 32'(bus.dispatch_idx), 0);

    foreach (vecs[n]) apply(vecs[n], n);

    // Both sources wake on two CDB slots in one cycle; no combinational bypass into select.
    @(negedge clock);
    idle();
    bus.flush = 1'b1;
    @(posedge clock); #1;
    chk("seq.flush_free_count", 32'(bus.free_count), 8);
    @(negedge clock);
    idle();
    bus.dispatch_en     = 1'b1;
    bus.dispatch_packet = mk_pkt(60, 1'b1, 7, 1'b1, 8);
    @(posedge clock); #1;
    chk("seq.pending_issue_valid", 32'(bus.issue_valid), 0);
    chk("seq.pending_free_count", 32'(bus.free_count), 7);
    @(negedge clock);
    idle();
    bus.cdb[0] = mk_tag(1'b1, 7);
    bus.cdb[1] = mk_tag(1'b1, 8);
    #1;
    chk("seq.no_bypass_issue_valid", 32'(bus.issue_valid), 0);
    @(posedge clock); #1;
    chk("seq.woken_issue_valid", 32'(bus.issue_valid), 1);
    chk("seq.woken_issue_idx", 32'(bus.issue_idx), 0);
    chk("seq.woken_pc", 32'(bus.issue_packet.pc), 60);
    chk("seq.woken_t1_ready", 32'(bus.issue_packet.t1.ready), 1);
    chk("seq.woken_t2_ready", 32'(bus.issue_packet.t2.ready), 1);
    @(negedge clock);
    idle();
    bus.issue_ready = 1'b1;
    waited = 0;
    do begin
      @(posedge clock); #1;
      waited++;
    end while (bus.issue_valid && waited < 10);
    chk("seq.accept_issue_valid", 32'(bus.issue_valid), 0);
    chk("seq.accept_cycles", 32'(waited), 1);
    chk("seq.accept_free_count", 32'(bus.free_count), 7);
    @(negedge clock);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_ooo.md
Name: rs_ooo

Overview:
- Parametrised reservation station for the R10K-style out-of-order core. Sits between dispatch (rename/map-table/free-list output) and the functional-unit issue stage.
- Holds RS_SZ fully-associative entries. Wakes operand tags from NUM_CDB broadcast buses.
- Selects the oldest ready entry each cycle, using an age matrix, and issues it over a valid/ready handshake.
- Supports per-index removal on completion and a global flush for mispredict recovery.

Parameters:
- RS_SZ, 8, number of entries (≥2, power of two not required)
- NUM_CDB, 2, number of CDB tag broadcasts checked per cycle
- IDX_W, $clog2(RS_SZ), entry index width (derived)
- CNT_W, $clog2(RS_SZ+1), free-count width (derived)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset; one clock, no other clock domains
- cdb  in  NUM_CDB x TAG  completed physical-register tags; slot active when .valid
- dispatch_packet  in  ID_IS_PACKET  renamed instruction with t, t1, t2 filled in
- dispatch_en  in  1  dispatch request
- dispatch_idx  out  IDX_W  entry that a dispatch this cycle will occupy (lowest free index)
- full  out  1  no free entry; dispatch is ignored
- free_count  out  CNT_W  number of non-busy entries
- issue_packet  out  ID_IS_PACKET  selected entry contents (ready bits as stored)
- issue_idx  out  IDX_W  selected entry index, later echoed back on remove_idx
- issue_valid  out  1  a ready, unissued entry exists
- issue_ready  in  1  FU accepts issue_packet this cycle
- remove_idx  in  IDX_W  entry to free on completion
- remove_en  in  1  removal strobe
- flush  in  1  squash all entries

Behaviour:
- Per-entry state: busy, issued, packet, and the age-matrix row age[i][*].
  - age[i][j]=1 means entry i is older than entry j.
- Reset (synchronous, active-high): all busy=0, issued=0, age matrix cleared. The resulting outputs are:
  - full=0, free_count=RS_SZ, issue_valid=0, dispatch_idx=0.
  - issue_packet and issue_idx are don't-care while issue_valid=0.
- Flush: same effect as reset. It has priority over dispatch, remove, issue and wakeup in the same cycle.
- Outputs: full, free_count, dispatch_idx, issue_* are combinational from registered state only. There is no combinational path from any input to any output.
- Dispatch: accepted iff dispatch_en && !full. On accept, the entry at dispatch_idx gets:
  - busy=1, issued=0, packet=dispatch_packet.
  - For t1/t2: if the tag is valid and matches any valid cdb slot this cycle, it is stored with ready=1 (same-cycle capture, no lost wakeup).
  - Age row: the new entry is marked younger than every currently busy entry. For all busy j: age[j][new]=1 and age[new][j]=0.
- Dispatch with full=1: dropped silently. The upstream block must stall on full.
- Wakeup: for every busy entry and each valid cdb slot k, if t1.valid && t1.phys_reg==cdb[k].phys_reg, set t1.ready next cycle. The same rule applies to t2. Multiple matching slots are harmless.
- Ready(i) = busy && !issued && (!t1.valid || t1.ready) && (!t2.valid || t2.ready). There is no same-cycle CDB bypass into select; wakeup-to-issue latency is 1 cycle.
- Select: pick the i with Ready(i) and no ready j older than i. issue_valid = OR over Ready.
- Issue handshake:
  - issue_valid && issue_ready sets issued[issue_idx]=1 at posedge; the entry stays busy.
  - While issue_ready=0, the selection may change if an older entry becomes ready. The FU samples only on the accepting edge.
- Remove: remove_en clears busy and issued of remove_idx next cycle.
  - Removing a non-busy entry is a no-op.
  - A freed entry is visible in free_count and full the following cycle; it is not reused in the same cycle.
- Simultaneous events:
  - Dispatch and remove in one cycle act on different entries, because dispatch_idx is never busy.
  - Issue accept and remove of the same index in one cycle: remove wins and the entry is freed.
  - Wakeup targeting the entry being dispatched into is handled by the capture rule above.
- free_count arithmetic: popcount of ~busy, CNT_W bits, never exceeds RS_SZ.

Decomposition:
- Shared package sys_defs.svh: TAG, ID_IS_PACKET (existing), plus a new RS_OOO_ENTRY struct {busy, issued, ID_IS_PACKET}.
- Sub-module rs_age_select: age matrix plus oldest-ready picker.
  - Inputs: ready vector, alloc one-hot, free one-hot, flush.
  - Outputs: grant one-hot and index.

Test Plan:
- Reset, then dispatch 8 packets with t1/t2 invalid → full=1, free_count=0, issue_valid=1, issue_idx=0; a 9th dispatch is ignored.
- Dispatch A(t1=PR5 not ready) into idx0, then B(ready) into idx1; cdb[0]=PR5 valid → B issues first; A issue_valid rises the cycle after wakeup; A is oldest and selected once ready.
- Dispatch C(t1=PR9) in the same cycle that cdb[1]=PR9 → C stored ready, issue_valid=1 next cycle.
- Hold issue_ready=0 for 3 cycles with one ready entry → issue_valid stays 1, issue_idx stable; raise issue_ready → issued set, issue_valid=0 next cycle; remove_en on that idx → free_count increments next cycle.
- Fill 5 entries, assert flush together with dispatch_en and remove_en → next cycle free_count=8, issue_valid=0, no entry busy.
- Remove entry 2 and dispatch in the same cycle with entries 0..3 busy → dispatch lands in idx4; next dispatch_idx=2.
